// File: rtl/ps2_mouse_if.sv
// PS/2 mouse receiver bus: raw device lines in, assembled packet word and error pulses out.
// The receiver uses the slave modport; whoever drives the device lines uses master.
interface ps2_mouse_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [24:0] ps2_mouse;
  logic        err_parity;
  logic        err_frame;

  modport master (output ps2_clk, ps2_data, input ps2_mouse, err_parity, err_frame);
  modport slave  (input ps2_clk, ps2_data, output ps2_mouse, err_parity, err_frame);
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronises and deglitches the device clock, decodes 11-bit frames
// and assembles 3-byte packets into a toggle-strobed word, with a stall timeout.
module ps2_mouse_rx #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  ps2_mouse_if.slave  bus
);
  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic        filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_ok_q, par_ok_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  byte0_q, byte0_d, byte1_q, byte1_d;
  logic [24:0] mouse_q, mouse_d;
  logic        err_par_q, err_par_d, err_frm_q, err_frm_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        fall_s, timeout_s, busy_s;
  logic        byte_ok_s, stop_bad_s, par_bad_s;

  assign fall_s    = filt_prev_q & ~filt_q;
  assign busy_s    = (state_q != IDLE) || (idx_q != 2'd0);
  // An edge in the same cycle as expiry wins, so expiry is masked by it.
  assign timeout_s = ~fall_s && (to_cnt_q == TW'(TIMEOUT));

  // Clock filter: level flips only after FILT consecutive samples at the new value.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILT - 1)) begin
        filt_d = clk_s2_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d = '0;
    end
  end

  // Bit-level FSM next state.
  always_comb begin
    state_d = state_q;
    if (timeout_s) begin
      state_d = IDLE;
    end else if (fall_s) begin
      case (state_q)
        IDLE:    state_d = dat_s2_q ? IDLE : DATA;
        DATA:    state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: byte verdict on the stop-bit edge; a bad stop bit masks bad parity.
  always_comb begin
    byte_ok_s  = 1'b0;
    stop_bad_s = 1'b0;
    par_bad_s  = 1'b0;
    if (fall_s && (state_q == STOP)) begin
      if (!dat_s2_q) begin
        stop_bad_s = 1'b1;
      end else if (!par_ok_q) begin
        par_bad_s = 1'b1;
      end else begin
        byte_ok_s = 1'b1;
      end
    end else begin
      byte_ok_s = 1'b0;
    end
  end

  // Datapath: bit shifting, packet assembly, timeout and error pulses.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    idx_d     = idx_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    mouse_d   = mouse_q;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    if (fall_s || timeout_s || !busy_s) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    if (timeout_s) begin
      bit_cnt_d = 3'd0;
      idx_d     = 2'd0;
      err_frm_d = 1'b1;
    end else if (fall_s) begin
      case (state_q)
        IDLE:    bit_cnt_d = 3'd0;
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY:  par_ok_d = ^{shift_q, dat_s2_q};
        default: bit_cnt_d = 3'd0;
      endcase
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    if (stop_bad_s) begin
      idx_d     = 2'd0;
      err_frm_d = 1'b1;
    end else if (par_bad_s) begin
      idx_d     = 2'd0;
      err_par_d = 1'b1;
    end else if (byte_ok_s) begin
      case (idx_q)
        2'd0: begin
          if (shift_q[3]) begin
            byte0_d = shift_q;
            idx_d   = 2'd1;
          end else begin
            err_frm_d = 1'b1;
          end
        end
        2'd1: begin
          byte1_d = shift_q;
          idx_d   = 2'd2;
        end
        2'd2: begin
          mouse_d = {~mouse_q[24], shift_q, byte1_q, byte0_q};
          idx_d   = 2'd0;
        end
        default: idx_d = 2'd0;
      endcase
    end else begin
      idx_d = idx_d;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Synchronisers, filter and datapath registers; synchronisers idle high like the bus.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_ok_q    <= 1'b0;
      idx_q       <= 2'd0;
      byte0_q     <= 8'd0;
      byte1_q     <= 8'd0;
      mouse_q     <= 25'd0;
      err_par_q   <= 1'b0;
      err_frm_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      clk_s1_q    <= bus.ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= bus.ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      idx_q       <= idx_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      mouse_q     <= mouse_d;
      err_par_q   <= err_par_d;
      err_frm_q   <= err_frm_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign bus.ps2_mouse  = mouse_q;
  assign bus.err_parity = err_par_q;
  assign bus.err_frame  = err_frm_q;
endmodule
